// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the iterative multiply/divide unit.
// Op encoding is {Div,Sign} and is also used by the decoder.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_FIX
   } md_state_e;

   localparam int MD_ITER = 32;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

endpackage

// File: rtl/muldiv_step.sv
// One multiply/divide iteration on the {hi,lo} working register.
// Multiply: add-or-pass then shift right. Divide: trial subtract.
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 div_i,
   input  logic [2*WIDTH-1:0]   p_i,
   input  logic [WIDTH-1:0]     m_i,
   output logic [2*WIDTH-1:0]   p_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic             ge;
   logic [WIDTH-1:0] rem;

   // single shift-add or shift-subtract step
   always_comb begin
      sum = {1'b0, p_i[2*WIDTH-1:WIDTH]}
          + {1'b0, (p_i[0] ? m_i : '0)};
      shl = p_i[2*WIDTH-1:WIDTH-1];
      ge  = shl >= {1'b0, m_i};
      rem = ge ? WIDTH'(shl - {1'b0, m_i})
               : shl[WIDTH-1:0];
      p_o = div_i ? {rem, p_i[WIDTH-2:0], ge}
                  : {sum, p_i[WIDTH-1:1]};
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// 32 CALC cycles plus one FIX cycle for sign correction.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Div,
   input  logic             Sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic               div_q, div_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg;
   logic [WIDTH:0]     a_ext, b_ext;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] p_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   // WIDTH+1-bit magnitudes so the most negative value survives
   always_comb begin
      a_neg = Sign & A[WIDTH-1];
      b_neg = Sign & B[WIDTH-1];
      a_ext = {a_neg, A};
      b_ext = {b_neg, B};
      a_mag = WIDTH'(a_neg ? -a_ext : a_ext);
      b_mag = WIDTH'(b_neg ? -b_ext : b_ext);
   end

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .div_i (div_q),
      .p_i   (p_q),
      .m_i   (m_q),
      .p_o   (p_step)
   );

   // sign-corrected views of the finished working register
   always_comb begin
      prod = negq_q ? -p_q : p_q;
      quo  = p_q[WIDTH-1:0];
      rem  = p_q[2*WIDTH-1:WIDTH];
   end

   // next-state, datapath load and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      m_d     = m_q;
      div_d   = div_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = (state_q == MD_FIX);
      unique case (state_q)
         MD_IDLE: begin
            if (HiWrite) hi_d = WData;
            if (LoWrite) lo_d = WData;
            if (Start) begin
               state_d = MD_CALC;
               cnt_d   = '0;
               div_d   = Div;
               negq_d  = a_neg ^ b_neg;
               negr_d  = a_neg;
               dz_d    = Div & ~|B;
               m_d     = Div ? b_mag : a_mag;
               p_d     = {{WIDTH{1'b0}},
                          (Div ? a_mag : b_mag)};
            end
         end
         MD_CALC: begin
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = MD_FIX;
         end
         MD_FIX: begin
            state_d = MD_IDLE;
            if (div_q) begin
               hi_d = negr_q ? -rem : rem;
               lo_d = dz_q ? '1
                    : (negq_q ? -quo : quo);
            end else begin
               {hi_d, lo_d} = prod;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // state and data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         div_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         div_q   <= div_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign Busy = (state_q != MD_IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Checks latency, Busy window, results, Start-ignore, mthi and reset.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         Start, Div, Sign;
   logic         HiWrite, LoWrite;
   logic [W-1:0] A, B, WData;
   logic         Busy, Done;
   logic [W-1:0] Hi, Lo;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   muldiv_unit #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .Div     (Div),
      .Sign    (Sign),
      .A       (A),
      .B       (B),
      .HiWrite (HiWrite),
      .LoWrite (LoWrite),
      .WData   (WData),
      .Busy    (Busy),
      .Done    (Done),
      .Hi      (Hi),
      .Lo      (Lo)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                    tag, got, exp);
   endtask

   // rs != 0: re-issue Start with other operands at that cycle
   task automatic run_op(input string tag,
                         input logic d, input logic s,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] ehi,
                         input logic [W-1:0] elo,
                         input int rs);
      int done_at = 0;
      int busy_n  = 0;
      @(negedge clk);
      Start = 1'b1;
      Div   = d;
      Sign  = s;
      A     = a;
      B     = b;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         Start = 1'b0;
         if (Busy) busy_n++;
         if (Done) begin
            done_at = k;
            break;
         end
         if (k == rs) begin
            Start = 1'b1;
            Div   = ~d;
            A     = 32'd100;
            B     = 32'd7;
         end
      end
      check({tag, " done_cycle"}, 64'(done_at), 64'd34);
      check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
      check({tag, " hi"}, 64'(Hi), 64'(ehi));
      check({tag, " lo"}, 64'(Lo), 64'(elo));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(Done), 64'd0);
   endtask

   initial begin
      int dn;
      reset   = 1'b1;
      Start   = 1'b0;
      Div     = 1'b0;
      Sign    = 1'b0;
      A       = '0;
      B       = '0;
      HiWrite = 1'b0;
      LoWrite = 1'b0;
      WData   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst busy", 64'(Busy), 64'd0);
      check("rst done", 64'(Done), 64'd0);
      check("rst hi",   64'(Hi),   64'd0);
      check("rst lo",   64'(Lo),   64'd0);

      run_op("multu7x6", 1'b0, 1'b0, 32'd7, 32'd6,
             32'h0, 32'h2A, 0);
      run_op("mult-3x5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,
             32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      run_op("multu_max", 1'b0, 1'b0, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0);
      run_op("mult_minsq", 1'b0, 1'b1, 32'h80000000,
             32'h80000000, 32'h40000000, 32'h0, 0);
      run_op("div-7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("divu100/7", 1'b1, 1'b0, 32'd100, 32'd7,
             32'd2, 32'd14, 0);
      run_op("div_ovf", 1'b1, 1'b1, 32'h80000000,
             32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
      run_op("divu_by0", 1'b1, 1'b0, 32'h1234, 32'h0,
             32'h1234, 32'hFFFFFFFF, 0);
      run_op("div_neg_by0", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h0,
             32'hFFFFFFF9, 32'hFFFFFFFF, 0);
      run_op("start_ign", 1'b0, 1'b0, 32'd7, 32'd6,
             32'h0, 32'h2A, 10);
      check("no_relaunch busy", 64'(Busy), 64'd0);

      @(negedge clk);
      HiWrite = 1'b1;
      WData   = 32'hABCD;
      @(negedge clk);
      HiWrite = 1'b0;
      check("mthi hi", 64'(Hi), 64'hABCD);
      check("mthi lo", 64'(Lo), 64'h2A);

      @(negedge clk);
      Start = 1'b1;
      Div   = 1'b0;
      Sign  = 1'b1;
      A     = 32'hFFFFFFFD;
      B     = 32'd5;
      @(posedge clk);
      for (int k = 1; k < 15; k++) begin
         @(negedge clk);
         Start = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst busy", 64'(Busy), 64'd0);
      check("midrst hi",   64'(Hi),   64'd0);
      check("midrst lo",   64'(Lo),   64'd0);
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Done) dn++;
      end
      check("midrst no_done", 64'(dn), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
